// File: rtl/mem_store_buffer.sv
// mem_store_buffer
// ----------------
// Word-granular store buffer placed in front of the data memory write port.
// Stores from the MEM stage are queued in a DEPTH-entry FIFO and drained to
// memory one per cycle whenever the port is not owned by a missing load.
// Loads that match a queued store are forwarded combinationally from the
// youngest matching entry.
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready.
// st_ready comes only from the registered occupancy, so it never depends on
// st_valid or on a drain happening in the same cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   st_valid/addr/data  store request from the pipeline (addr[1:0] ignored)
//   st_ready          buffer not full; low means the pipeline must stall
//   ld_valid/addr     load lookup from the pipeline (addr[1:0] ignored)
//   ld_hit, ld_data   forwarding result (ld_data is 0 when ld_hit is 0)
//   mem_we/addr/datain  write port to data memory (head entry)
//   empty             no stores pending
module mem_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hit,
   output logic [31:0] ld_data,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic        empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;

   logic          enq;
   logic          drain;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [PW-1:0] scan_idx;

   // Byte-offset bits of the addresses are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

   assign st_ready = (count_q != FULL_CNT);
   assign empty    = (count_q == '0);
   assign enq      = st_valid & st_ready;

   // Walk entries from oldest (head) to youngest; a later match overwrites an
   // earlier one so the youngest matching store supplies the data. The entry
   // being drained this cycle is still occupied and therefore still visible.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PW'(i);
         if (((PW+1)'(i) < count_q) && (addr_q[scan_idx] == ld_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[scan_idx];
         end
      end
   end

   assign ld_hit  = ld_valid & fwd_hit;
   assign ld_data = ld_hit ? fwd_data : 32'h0;

   // A load that misses needs the memory port for its read, so it blocks the
   // drain for this cycle only.
   assign drain = (count_q != '0) & ~(ld_valid & ~ld_hit);

   assign mem_we     = drain;
   assign mem_addr   = {addr_q[head_q], 2'b00};
   assign mem_datain = data_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) begin
         head_d = head_q + 1'b1;
      end
      if (enq) begin
         tail_d = tail_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is reset as well so mem_addr/mem_datain read as zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (enq) begin
         addr_q[tail_q] <= st_addr[31:2];
         data_q[tail_q] <= st_data;
      end
   end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_datain;
   logic        empty;

   int n_vec = 0;
   int n_err = 0;

   // expected memory writes: {word address, data}
   logic [63:0] exp_q[$];

   mem_store_buffer #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_ready  (st_ready),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_datain(mem_datain),
      .empty     (empty)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present a store, wait (bounded) for st_ready, record the expected write.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      int waited;
      waited   = 0;
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      @(negedge clk);
      while (!st_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!st_ready) chk("st_ready_wait", {31'h0, st_ready}, 32'h1);
      exp_q.push_back({a[31:2], 2'b00, d});
      cyc();
      st_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (!empty && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'h0, empty}, 32'h1);
      chk({name, "_sb"}, exp_q.size(), 32'h0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", mem_addr, e[63:32]);
            chk("wr_data", mem_datain, e[31:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b1;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      ld_valid = 1'b0;
      ld_addr  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
      chk("rst_empty",    {31'h0, empty},    32'h1);
      chk("rst_mem_we",   {31'h0, mem_we},   32'h0);
      chk("rst_ld_hit",   {31'h0, ld_hit},   32'h0);
      chk("rst_mem_addr", mem_addr,          32'h0);
      cyc();
      rst = 1'b0;

      // ---- single store ----
      do_store(32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("single_we",   {31'h0, mem_we}, 32'h1);
      chk("single_addr", mem_addr,        32'h10);
      chk("single_data", mem_datain,      32'hDEADBEEF);
      cyc();
      @(negedge clk);
      chk("single_empty", {31'h0, empty},  32'h1);
      chk("single_we_lo", {31'h0, mem_we}, 32'h0);
      cyc();

      // ---- full / backpressure ----
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
      do_store(32'h0, 32'hA0);
      do_store(32'h4, 32'hA1);
      do_store(32'h8, 32'hA2);
      do_store(32'hC, 32'hA3);
      st_valid = 1'b1;
      st_addr  = 32'h10;
      st_data  = 32'hA4;
      @(negedge clk);
      chk("full_ready",  {31'h0, st_ready}, 32'h0);
      chk("full_we",     {31'h0, mem_we},   32'h0);
      chk("full_empty",  {31'h0, empty},    32'h0);
      cyc();
      @(negedge clk);
      chk("full_hold_ready", {31'h0, st_ready}, 32'h0);
      cyc();
      ld_valid = 1'b0;
      @(negedge clk);
      chk("full_drain_ready", {31'h0, st_ready}, 32'h0);
      chk("full_drain_we",    {31'h0, mem_we},   32'h1);
      chk("full_drain_addr",  mem_addr,          32'h0);
      cyc();
      @(negedge clk);
      chk("full_ready_back", {31'h0, st_ready}, 32'h1);
      exp_q.push_back({32'h10, 32'hA4});
      cyc();
      st_valid = 1'b0;
      wait_empty("full_empty_end");
      cyc();

      // ---- forwarding ----
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
      do_store(32'h20, 32'h1);
      do_store(32'h20, 32'h2);
      do_store(32'h24, 32'h3);
      ld_addr = 32'h22;
      @(negedge clk);
      chk("fwd22_hit",  {31'h0, ld_hit}, 32'h1);
      chk("fwd22_data", ld_data,         32'h2);
      cyc();
      ld_addr = 32'h24;
      @(negedge clk);
      chk("fwd24_hit",  {31'h0, ld_hit}, 32'h1);
      chk("fwd24_data", ld_data,         32'h3);
      cyc();
      ld_addr = 32'h28;
      @(negedge clk);
      chk("fwd28_hit",  {31'h0, ld_hit}, 32'h0);
      chk("fwd28_data", ld_data,         32'h0);
      chk("fwd28_we",   {31'h0, mem_we}, 32'h0);
      cyc();
      // store in the same cycle as a load to the same word is not visible yet
      st_valid = 1'b1;
      st_addr  = 32'h30;
      st_data  = 32'h4;
      ld_addr  = 32'h30;
      exp_q.push_back({32'h30, 32'h4});
      @(negedge clk);
      chk("fwd_same_cycle_hit", {31'h0, ld_hit},   32'h0);
      chk("fwd_same_cycle_rdy", {31'h0, st_ready}, 32'h1);
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
      chk("fwd_next_cycle_hit",  {31'h0, ld_hit}, 32'h1);
      chk("fwd_next_cycle_data", ld_data,         32'h4);
      cyc();
      ld_valid = 1'b0;
      wait_empty("fwd_empty_end");
      cyc();

      // ---- concurrent enqueue / drain at count 3 ----
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
      do_store(32'h40, 32'hC0);
      do_store(32'h44, 32'hC1);
      do_store(32'h48, 32'hC2);
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         st_valid = 1'b1;
         st_addr  = 32'h4C + 32'(4 * k);
         st_data  = 32'hD0 + 32'(k);
         exp_q.push_back({st_addr, st_data});
         @(negedge clk);
         chk("conc_ready", {31'h0, st_ready}, 32'h1);
         chk("conc_we",    {31'h0, mem_we},   32'h1);
         chk("conc_addr",  mem_addr,          32'h40 + 32'(4 * k));
         cyc();
      end
      st_valid = 1'b0;
      wait_empty("conc_empty_end");
      cyc();

      // ---- pointer wrap with interleaved load blocks ----
      for (int i = 0; i < 10; i++) begin
         ld_valid = ((i % 3) == 1);
         ld_addr  = 32'h900;
         do_store(32'h200 + 32'(4 * i), 32'h1000 + 32'(i * 32'h11));
         ld_valid = 1'b0;
      end
      wait_empty("wrap_empty_end");
      cyc();

      // ---- reset mid-cycle with 2 entries queued ----
      ld_valid = 1'b1;
      ld_addr  = 32'h100;
      do_store(32'h300, 32'h11);
      do_store(32'h304, 32'h22);
      ld_addr = 32'h300;
      #1;
      chk("prerst_hit",  {31'h0, ld_hit}, 32'h1);
      chk("prerst_data", ld_data,         32'h11);
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_we",     {31'h0, mem_we},   32'h0);
      chk("midrst_empty",  {31'h0, empty},    32'h1);
      chk("midrst_ready",  {31'h0, st_ready}, 32'h1);
      chk("midrst_hit",    {31'h0, ld_hit},   32'h0);
      chk("midrst_data",   ld_data,           32'h0);
      chk("midrst_maddr",  mem_addr,          32'h0);
      chk("midrst_mdata",  mem_datain,        32'h0);
      cyc();
      rst      = 1'b0;
      ld_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("postrst_empty", {31'h0, empty}, 32'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
